// File: rtl/program_loader_if.sv
// Byte-stream intake and instruction-memory write bus of the boot loader.
// master is the loader's view; slave is the stream source / memory side.
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imu_wen;
  logic [ADDR_W-1:0] imu_addr;
  logic [DATA_W-1:0] imu_data_in;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imu_wen, imu_addr, imu_data_in
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imu_wen, imu_addr, imu_data_in
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: count byte, big-endian 32-bit payload words written to
// consecutive instruction-memory addresses, XOR checksum gates CPU release.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  program_loader_if.master    bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [8:0]          words_loaded
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COUNT   = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] ERROR   = 3'd5;

  logic [2:0]  state, state_nxt;
  logic [7:0]  words_left;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [23:0] shift;
  logic        accept;

  assign accept = bus.rx_valid & bus.rx_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COUNT;
      COUNT:   if (accept) state_nxt = (bus.rx_data == 8'd0) ? CHECK : PAYLOAD;
      PAYLOAD: if (accept && byte_idx == 2'd3 && words_left == 8'd1) state_nxt = CHECK;
      CHECK:   if (accept) state_nxt = (bus.rx_data == csum) ? DONE : ERROR;
      DONE:    if (start) state_nxt = COUNT;
      ERROR:   if (start) state_nxt = COUNT;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change in the
  // same cycle the state does.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state           <= IDLE;
      bus.rx_ready    <= 1'b0;
      bus.imu_wen     <= 1'b0;
      bus.imu_addr    <= {ADDR_W{1'b0}};
      bus.imu_data_in <= {DATA_W{1'b0}};
      cpu_hold        <= 1'b1;
      done            <= 1'b0;
      error           <= 1'b0;
      words_loaded    <= 9'd0;
      words_left      <= 8'd0;
      byte_idx        <= 2'd0;
      csum            <= 8'd0;
      shift           <= 24'd0;
    end else begin
      state        <= state_nxt;
      bus.rx_ready <= (state_nxt == COUNT) || (state_nxt == PAYLOAD) || (state_nxt == CHECK);
      cpu_hold     <= (state_nxt != DONE);
      done         <= (state_nxt == DONE);
      error        <= (state_nxt == ERROR);
      bus.imu_wen  <= 1'b0;

      // The address advances on the edge after each strobe.
      if (bus.imu_wen) begin
        bus.imu_addr <= bus.imu_addr + ADDR_W'(1);
        words_loaded <= words_loaded + 9'd1;
      end

      if (accept) begin
        case (state)
          COUNT: begin
            words_left   <= bus.rx_data;
            byte_idx     <= 2'd0;
            csum         <= 8'd0;
            bus.imu_addr <= {ADDR_W{1'b0}};
            words_loaded <= 9'd0;
          end
          PAYLOAD: begin
            shift    <= {shift[15:0], bus.rx_data};
            csum     <= csum ^ bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            // Word goes to its own register so the next byte can shift in
            // during the strobe cycle.
            if (byte_idx == 2'd3) begin
              bus.imu_wen     <= 1'b1;
              bus.imu_data_in <= DATA_W'({shift, bus.rx_data});
              words_left      <= words_left - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
